// File: rtl/mips_register_file.sv
// MIPS-style register file: two combinational read ports, one write port,
// hardwired-zero r0, async active-high clear and optional write-to-read forwarding.

module mips_rf_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (we) q <= d;
  end
endmodule

module mips_rf_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic                                reset,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]  regs,
  input  logic [ADDR_W-1:0]                   raddr,
  input  logic                                fwd_en,
  input  logic [ADDR_W-1:0]                   waddr,
  input  logic [DATA_W-1:0]                   wdata,
  output logic [DATA_W-1:0]                   rdata
);
  logic [DATA_W-1:0] raw;

  // Forwarding mux exists only when BYPASS=1, so WriteData never reaches
  // the read outputs combinationally in the non-bypass build.
  generate
    if (BYPASS != 0) begin : g_fwd
      always_comb begin
        raw = regs[raddr];
        if (fwd_en && (raddr == waddr)) raw = wdata;
      end
    end else begin : g_nofwd
      always_comb raw = regs[raddr];
    end
  endgenerate

  assign rdata = (reset || (raddr == '0)) ? '0 : raw;
endmodule

module mips_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  localparam int NREG = 1 << ADDR_W;
  localparam int NRD  = 2;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             we_vec;
  logic                        wr_ok;
  logic [NRD-1:0][ADDR_W-1:0]  raddr;
  logic [NRD-1:0][DATA_W-1:0]  rdata;

  // A qualified write: enabled, not to r0, and not while reset holds the array.
  assign wr_ok = RegWrite && (WriteReg != '0) && !reset;

  assign regs[0]   = '0;
  assign we_vec[0] = 1'b0;

  generate
    for (genvar i = 1; i < NREG; i++) begin : g_reg
      assign we_vec[i] = wr_ok && (WriteReg == ADDR_W'(i));
      mips_rf_cell #(.DATA_W(DATA_W)) u_cell (
        .clk   (clk),
        .reset (reset),
        .we    (we_vec[i]),
        .d     (WriteData),
        .q     (regs[i])
      );
    end
  endgenerate

  assign raddr = {ReadReg2, ReadReg1};

  generate
    for (genvar p = 0; p < NRD; p++) begin : g_rd
      mips_rf_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd (
        .reset  (reset),
        .regs   (regs),
        .raddr  (raddr[p]),
        .fwd_en (wr_ok),
        .waddr  (WriteReg),
        .wdata  (WriteData),
        .rdata  (rdata[p])
      );
    end
  endgenerate

  assign ReadData1 = rdata[0];
  assign ReadData2 = rdata[1];
endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench: a forwarding and a non-forwarding register file share
// stimulus; expectations are queued and checked by a negedge monitor.
module tb_mips_register_file;
  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] bp_rd1, bp_rd2, nb_rd1, nb_rd2;

  typedef struct {
    string       nm;
    logic [31:0] b1, b2, n1, n2;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(bp_rd1), .ReadData2(bp_rd2)
  );

  mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(nb_rd1), .ReadData2(nb_rd2)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp({e.nm, ".bp1"}, bp_rd1, e.b1);
      cmp({e.nm, ".bp2"}, bp_rd2, e.b2);
      cmp({e.nm, ".nb1"}, nb_rd1, e.n1);
      cmp({e.nm, ".nb2"}, nb_rd2, e.n2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect4(input string nm, input logic [31:0] b1, b2, n1, n2);
    exp_t e;
    e.nm = nm; e.b1 = b1; e.b2 = b2; e.n1 = n1; e.n2 = n2;
    q.push_back(e);
  endtask

  task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2);
    RegWrite = we; WriteReg = wa; WriteData = wd; ReadReg1 = r1; ReadReg2 = r2;
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cyc();
    // Write attempted while reset is high: outputs and bypass forced to zero.
    drv(1'b1, 5'd8, 32'h1111_1111, 5'd8, 5'd8);
    expect4("rst_wr", 32'h0, 32'h0, 32'h0, 32'h0);
    cyc();
    reset = 1'b0;
    drv(1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
    expect4("rst_blocked", 32'h0, 32'h0, 32'h0, 32'h0);

    for (int a = 0; a < 32; a++) begin
      cyc();
      drv(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
      expect4($sformatf("clr%0d", a), 32'h0, 32'h0, 32'h0, 32'h0);
    end

    // DEADBEEF -> r8, CAFEBABE -> r9
    cyc(); drv(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd9);
    expect4("w8", 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    cyc(); drv(1'b1, 5'd9, 32'hCAFE_BABE, 5'd8, 5'd9);
    expect4("w9", 32'hDEAD_BEEF, 32'hCAFE_BABE, 32'hDEAD_BEEF, 32'h0);
    cyc(); drv(1'b0, 5'd9, 32'h0, 5'd8, 5'd9);
    expect4("rd89", 32'hDEAD_BEEF, 32'hCAFE_BABE, 32'hDEAD_BEEF, 32'hCAFE_BABE);
    for (int a = 0; a < 32; a++) begin
      if (a == 8 || a == 9) continue;
      cyc(); drv(1'b0, 5'd0, 32'h0, 5'(a), 5'(a));
      expect4($sformatf("other%0d", a), 32'h0, 32'h0, 32'h0, 32'h0);
    end

    // Write to r0 discarded, r0 reads zero even during the write.
    cyc(); drv(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    expect4("w0_inflight", 32'h0, 32'h0, 32'h0, 32'h0);
    cyc(); drv(1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    expect4("w0_after", 32'h0, 32'h0, 32'h0, 32'h0);

    // Forwarding vs stored-value timing on r5, back-to-back writes.
    cyc(); drv(1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
    expect4("w5a", 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0);
    cyc(); drv(1'b1, 5'd5, 32'h8765_4321, 5'd5, 5'd5);
    expect4("w5b", 32'h8765_4321, 32'h8765_4321, 32'h1234_5678, 32'h1234_5678);
    cyc(); drv(1'b0, 5'd5, 32'h0, 5'd5, 5'd5);
    expect4("r5", 32'h8765_4321, 32'h8765_4321, 32'h8765_4321, 32'h8765_4321);

    // RegWrite=0 holds r3 over several edges.
    cyc(); drv(1'b1, 5'd3, 32'h3333_3333, 5'd0, 5'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); drv(1'b0, 5'd3, 32'hAAAA_AAAA, 5'd3, 5'd8);
      expect4($sformatf("hold3_%0d", k), 32'h3333_3333, 32'hDEAD_BEEF,
              32'h3333_3333, 32'hDEAD_BEEF);
    end

    // Reset mid-cycle clears immediately; first write after release lands.
    cyc(); drv(1'b1, 5'd31, 32'h5555_5555, 5'd0, 5'd0);
    cyc(); drv(1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    expect4("r31", 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555);
    cyc();
    reset = 1'b1;
    expect4("rst_async", 32'h0, 32'h0, 32'h0, 32'h0);
    cyc(); drv(1'b1, 5'd31, 32'hFACE_FACE, 5'd31, 5'd8);
    expect4("rst_wedge", 32'h0, 32'h0, 32'h0, 32'h0);
    cyc();
    reset = 1'b0;
    expect4("post_rst_fwd", 32'hFACE_FACE, 32'h0, 32'h0, 32'h0);
    cyc(); drv(1'b0, 5'd0, 32'h0, 5'd31, 5'd8);
    expect4("post_rst_wr", 32'hFACE_FACE, 32'h0, 32'hFACE_FACE, 32'h0);

    cyc();
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
